// File: rtl/led_flicker_ctrl.sv
// led_flicker_ctrl: LED cell flicker sequencer (off/steady/slow/fast blink) loaded on reset release.
module led_flicker_ctrl #(
  parameter int CNT_W     = 4,
  parameter bit START_LIT = 1'b1
) (
  input  logic             led_flicker_clk_rst,
  input  logic             src_slow,
  input  logic             src_fast,
  input  logic [1:0]       req_mode,
  input  logic [CNT_W-1:0] req_count,
  output logic             flicker_out,
  output logic             active,
  output logic             blink_done
);
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] limit_q;
  logic [1:0]       src, phase_r, done_r;
  logic             sel_phase, sel_done;
  assign src = {src_fast, src_slow};
  always_ff @(negedge led_flicker_clk_rst) begin
    mode_q  <= req_mode;
    limit_q <= req_count;
  end
  // One engine per source so neither clock is muxed; engines held in reset while the pulse is high.
  genvar e;
  generate
    for (e = 0; e < 2; e++) begin : g_eng
      logic             phase, done, run;
      logic [CNT_W-1:0] cyc, cyc_inc;
      assign run        = mode_q == {1'b1, 1'(e)} && !done;
      assign cyc_inc    = cyc + 1'b1;
      assign phase_r[e] = phase;
      assign done_r[e]  = done;
      always_ff @(posedge src[e] or posedge led_flicker_clk_rst) begin
        if (led_flicker_clk_rst) begin
          phase <= ~START_LIT;
          cyc   <= '0;
          done  <= 1'b0;
        end else if (run) begin
          phase <= ~phase;
          if (phase == START_LIT) begin
            cyc <= &cyc ? cyc : cyc_inc;
            if (limit_q != '0 && cyc_inc == limit_q) done <= 1'b1;
          end
        end
      end
    end
  endgenerate
  assign sel_phase   = phase_r[mode_q[0]];
  assign sel_done    = mode_q[1] & done_r[mode_q[0]];
  assign flicker_out = led_flicker_clk_rst ? 1'b1 : mode_q[1] ? ~sel_phase : mode_q[0];
  assign active      = !led_flicker_clk_rst && mode_q != 2'b00 && !sel_done;
  assign blink_done  = sel_done;
endmodule

// File: tb/tb_led_flicker_ctrl.sv
// tb_led_flicker_ctrl: randomized and directed checks of led_flicker_ctrl against an edge-counting model.
module tb_led_flicker_ctrl;
  logic       clk_rst = 1'b1, src_slow = 1'b0, src_fast = 1'b0;
  logic [1:0] req_mode = 2'b00;
  logic [3:0] req_count = 4'd0;
  logic       flicker_out, active, blink_done;
  logic [2:0] got;
  int         checks = 0, fails = 0;
  bit         m_rst = 1'b1;
  logic [1:0] m_mode = 2'b00;
  int         m_lim = 0, m_n = 0;

  led_flicker_ctrl #(.CNT_W(4), .START_LIT(1'b1)) dut (
    .led_flicker_clk_rst(clk_rst), .src_slow(src_slow), .src_fast(src_fast),
    .req_mode(req_mode), .req_count(req_count),
    .flicker_out(flicker_out), .active(active), .blink_done(blink_done)
  );

  // Expected {flicker_out, active, blink_done}: a blink sequence is just a count of counted
  // edges, lit on even counts, frozen at 2*limit once the limit is reached.
  function automatic logic [2:0] model();
    bit d;
    int eff;
    if (m_rst) return 3'b100;
    d   = m_mode[1] && m_lim != 0 && m_n >= 2 * m_lim;
    eff = d ? 2 * m_lim : m_n;
    return {m_mode[1] ? (eff % 2 == 0) : m_mode[0], m_mode != 2'b00 && !d, d};
  endfunction

  task automatic go(input logic [1:0] mode, input logic [3:0] count);
    if (!clk_rst) begin
      clk_rst = 1'b1;
      m_rst = 1'b1;
      #5;
    end
    req_mode = mode;
    req_count = count;
    #5;
    clk_rst = 1'b0;
    m_rst = 1'b0;
    m_mode = mode;
    m_lim = count;
    m_n = 0;
    #2;
    req_mode = 2'($urandom);
    req_count = 4'($urandom);
    #2;
  endtask

  task automatic hold_rst();
    clk_rst = 1'b1;
    m_rst = 1'b1;
    #2;
  endtask

  task automatic pulse_src(input bit f);
    if (f) src_fast = 1'b1;
    else src_slow = 1'b1;
    if (!m_rst && m_mode[1] && m_mode[0] == f) m_n++;
    #3;
    src_fast = 1'b0;
    src_slow = 1'b0;
    #3;
  endtask

  task automatic test_reset();
    req_mode = 2'b10;
    req_count = 4'd2;
    hold_rst();
    got = {flicker_out, active, blink_done};
    checks++;
    if (got !== model()) begin fails++; $display("FAIL reset_state: got %b expected %b", got, model()); end
  endtask

  task automatic test_slow_count();
    go(2'b10, 4'd2);
    got = {flicker_out, active, blink_done};
    checks++;
    if (got !== 3'b110) begin fails++; $display("FAIL slow_release: got %b expected 110", got); end
    for (int i = 1; i <= 5; i++) begin
      pulse_src(1'b0);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL slow_count edge %0d: got %b expected %b", i, got, model()); end
    end
    checks++;
    if (got !== 3'b101) begin fails++; $display("FAIL slow_count final: got %b expected 101", got); end
  endtask

  task automatic test_fast_sel();
    go(2'b11, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      pulse_src(1'b0);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL fast_sel slow edge %0d: got %b expected %b", i, got, model()); end
    end
    for (int i = 1; i <= 6; i++) begin
      pulse_src(1'b1);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL fast_sel fast edge %0d: got %b expected %b", i, got, model()); end
    end
  endtask

  task automatic test_unlimited();
    go(2'b10, 4'd0);
    for (int i = 1; i <= 40; i++) begin
      pulse_src(1'b0);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL unlimited edge %0d: got %b expected %b", i, got, model()); end
    end
  endtask

  task automatic test_mid_reset();
    go(2'b10, 4'd5);
    repeat (3) pulse_src(1'b0);
    got = {flicker_out, active, blink_done};
    checks++;
    if (got !== model()) begin fails++; $display("FAIL mid_reset before: got %b expected %b", got, model()); end
    hold_rst();
    got = {flicker_out, active, blink_done};
    checks++;
    if (got !== model()) begin fails++; $display("FAIL mid_reset held: got %b expected %b", got, model()); end
    go(2'b01, 4'd3);
    for (int i = 0; i < 4; i++) begin
      pulse_src(i[0]);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL steady edge %0d: got %b expected %b", i, got, model()); end
    end
  endtask

  task automatic test_off_hold();
    go(2'b00, 4'd7);
    got = {flicker_out, active, blink_done};
    checks++;
    if (got !== 3'b000) begin fails++; $display("FAIL off_mode: got %b expected 000", got); end
    hold_rst();
    for (int i = 1; i <= 10; i++) begin
      pulse_src(1'b1);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL hold_rst edge %0d: got %b expected %b", i, got, model()); end
    end
  endtask

  task automatic test_coincident();
    hold_rst();
    req_mode = 2'b10;
    req_count = 4'd1;
    #5;
    src_slow = 1'b1;
    #0;
    clk_rst = 1'b0;
    m_rst = 1'b0;
    m_mode = 2'b10;
    m_lim = 1;
    m_n = 0;
    #3;
    got = {flicker_out, active, blink_done};
    checks++;
    if (got !== model()) begin fails++; $display("FAIL coincident release: got %b expected %b", got, model()); end
    src_slow = 1'b0;
    #3;
    for (int i = 1; i <= 2; i++) begin
      pulse_src(1'b0);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL coincident edge %0d: got %b expected %b", i, got, model()); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) go(2'($urandom), 4'($urandom_range(0, 4)));
      else if (r == 11) hold_rst();
      else pulse_src(r > 5);
      got = {flicker_out, active, blink_done};
      checks++;
      if (got !== model()) begin fails++; $display("FAIL random step %0d op %0d: got %b expected %b", i, r, got, model()); end
    end
  endtask

  initial begin
    #5;
    test_reset();
    test_slow_count();
    test_fast_sel();
    test_unlimited();
    test_mid_reset();
    test_off_hold();
    test_coincident();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
